// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: tracks prefixes and modifiers, translates make
// codes to ASCII and queues the characters in a FIFO for the CPU to pop.
module ps2_scancode_decoder #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             system_clk,
    input  logic             reset,
    input  logic             scan_valid,
    input  logic [7:0]       scan_code,
    input  logic             scan_error,
    input  logic             read_character,
    output logic [7:0]       char_out,
    output logic             char_available,
    output logic [CNT_W-1:0] char_count,
    output logic             overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    state_t state_q, state_d;
    logic shift_l_q, shift_l_d;
    logic shift_r_q, shift_r_d;
    logic ctrl_q, ctrl_d;
    logic caps_q, caps_d;
    logic push_q, push_d;
    logic [7:0] push_char_q, push_char_d;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_d;
    logic             pop, full, wr_en, drop;
    logic [7:0]       head_d;

    logic       shift;
    logic [8:0] letter;
    logic [16:0] digit;

    // {hit, lowercase ascii}
    function automatic logic [8:0] letter_of(input logic [7:0] code);
        logic [8:0] r;
        r = 9'h000;
        case (code)
            8'h1C: r = {1'b1, 8'h61};
            8'h32: r = {1'b1, 8'h62};
            8'h21: r = {1'b1, 8'h63};
            8'h23: r = {1'b1, 8'h64};
            8'h24: r = {1'b1, 8'h65};
            8'h2B: r = {1'b1, 8'h66};
            8'h34: r = {1'b1, 8'h67};
            8'h33: r = {1'b1, 8'h68};
            8'h43: r = {1'b1, 8'h69};
            8'h3B: r = {1'b1, 8'h6A};
            8'h42: r = {1'b1, 8'h6B};
            8'h4B: r = {1'b1, 8'h6C};
            8'h3A: r = {1'b1, 8'h6D};
            8'h31: r = {1'b1, 8'h6E};
            8'h44: r = {1'b1, 8'h6F};
            8'h4D: r = {1'b1, 8'h70};
            8'h15: r = {1'b1, 8'h71};
            8'h2D: r = {1'b1, 8'h72};
            8'h1B: r = {1'b1, 8'h73};
            8'h2C: r = {1'b1, 8'h74};
            8'h3C: r = {1'b1, 8'h75};
            8'h2A: r = {1'b1, 8'h76};
            8'h1D: r = {1'b1, 8'h77};
            8'h22: r = {1'b1, 8'h78};
            8'h35: r = {1'b1, 8'h79};
            8'h1A: r = {1'b1, 8'h7A};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // {hit, plain digit, shifted symbol}
    function automatic logic [16:0] digit_of(input logic [7:0] code);
        logic [16:0] r;
        r = 17'h00000;
        case (code)
            8'h45: r = {1'b1, 8'h30, 8'h29};
            8'h16: r = {1'b1, 8'h31, 8'h21};
            8'h1E: r = {1'b1, 8'h32, 8'h40};
            8'h26: r = {1'b1, 8'h33, 8'h23};
            8'h25: r = {1'b1, 8'h34, 8'h24};
            8'h2E: r = {1'b1, 8'h35, 8'h25};
            8'h36: r = {1'b1, 8'h36, 8'h5E};
            8'h3D: r = {1'b1, 8'h37, 8'h26};
            8'h3E: r = {1'b1, 8'h38, 8'h2A};
            8'h46: r = {1'b1, 8'h39, 8'h28};
            default: r = 17'h00000;
        endcase
        return r;
    endfunction

    // Prefix/modifier state register plus the one-cycle push stage
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            ctrl_q      <= 1'b0;
            caps_q      <= 1'b0;
            push_q      <= 1'b0;
            push_char_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            ctrl_q      <= ctrl_d;
            caps_q      <= caps_d;
            push_q      <= push_d;
            push_char_q <= push_char_d;
        end
    end

    // Next-state, modifier update and translation
    always_comb begin
        state_d     = state_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        ctrl_d      = ctrl_q;
        caps_d      = caps_q;
        push_d      = 1'b0;
        push_char_d = 8'h00;
        shift       = shift_l_q | shift_r_q;
        letter      = letter_of(scan_code);
        digit       = digit_of(scan_code);

        if (scan_error) begin
            state_d = ST_IDLE;
        end else if (scan_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_code == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (scan_code == 8'hE0) begin
                        state_d = ST_EXT;
                    end else begin
                        case (scan_code)
                            8'h12: shift_l_d = 1'b1;
                            8'h59: shift_r_d = 1'b1;
                            8'h14: ctrl_d    = 1'b1;
                            8'h58: caps_d    = ~caps_q;
                            8'h29: begin push_d = 1'b1; push_char_d = 8'h20; end
                            8'h5A: begin push_d = 1'b1; push_char_d = 8'h0D; end
                            8'h66: begin push_d = 1'b1; push_char_d = 8'h08; end
                            8'h0D: begin push_d = 1'b1; push_char_d = 8'h09; end
                            8'h76: begin push_d = 1'b1; push_char_d = 8'h1B; end
                            default: begin
                                if (letter[8]) begin
                                    push_d = 1'b1;
                                    if (ctrl_q)
                                        push_char_d = letter[7:0] & 8'h1F;
                                    else if (shift ^ caps_q)
                                        push_char_d = letter[7:0] - 8'h20;
                                    else
                                        push_char_d = letter[7:0];
                                end else if (digit[16]) begin
                                    push_d      = 1'b1;
                                    push_char_d = shift ? digit[7:0] : digit[15:8];
                                end
                            end
                        endcase
                    end
                end
                ST_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                        if (scan_code == 8'h14) begin
                            ctrl_d = 1'b1;
                        end else if (scan_code == 8'h5A) begin
                            push_d      = 1'b1;
                            push_char_d = 8'h0D;
                        end
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    case (scan_code)
                        8'h12:   shift_l_d = 1'b0;
                        8'h59:   shift_r_d = 1'b0;
                        8'h14:   ctrl_d    = 1'b0;
                        default: ;
                    endcase
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                    if (scan_code == 8'h14)
                        ctrl_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FIFO control; a pop frees a slot so push+pop while full is accepted
    always_comb begin
        pop      = read_character && (char_count != '0);
        full     = (char_count == CNT_W'(DEPTH));
        wr_en    = push_q && (!full || pop);
        drop     = push_q && full && !pop;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = char_count;
        if (wr_en && !pop)
            count_d = char_count + CNT_W'(1);
        else if (pop && !wr_en)
            count_d = char_count - CNT_W'(1);
        // The entry being written this cycle may already be the new head
        if (count_d == '0)
            head_d = 8'h00;
        else if (wr_en && (rd_ptr_d == wr_ptr_q))
            head_d = push_char_q;
        else
            head_d = mem[rd_ptr_d];
    end

    always_ff @(posedge system_clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= push_char_q;
    end

    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            char_count     <= '0;
            char_out       <= 8'h00;
            char_available <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            rd_ptr_q       <= rd_ptr_d;
            char_count     <= count_d;
            char_out       <= head_d;
            char_available <= (count_d != '0);
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: vector table of key sequences
// plus hand-written FIFO, overflow, error and reset sequences.
module tb_ps2_scancode_decoder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 5;

    logic             system_clk;
    logic             reset;
    logic             scan_valid;
    logic [7:0]       scan_code;
    logic             scan_error;
    logic             read_character;
    logic [7:0]       char_out;
    logic             char_available;
    logic [CNT_W-1:0] char_count;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    ps2_scancode_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .system_clk     (system_clk),
        .reset          (reset),
        .scan_valid     (scan_valid),
        .scan_code      (scan_code),
        .scan_error     (scan_error),
        .read_character (read_character),
        .char_out       (char_out),
        .char_available (char_available),
        .char_count     (char_count),
        .overflow       (overflow)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [47:0] codes;
        int          n;
        logic        push;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] b3,
                                 input logic [7:0] b4, input logic [7:0] b5,
                                 input logic push, input logic [7:0] exp);
        vec_t v;
        v.codes = {b5, b4, b3, b2, b1, b0};
        v.n     = n;
        v.push  = push;
        v.exp   = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge system_clk);
        scan_valid = 1'b1;
        scan_code  = b;
        @(negedge system_clk);
        scan_valid = 1'b0;
        scan_code  = 8'h00;
    endtask

    task automatic pop_char();
        @(negedge system_clk);
        read_character = 1'b1;
        @(negedge system_clk);
        read_character = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge system_clk);
    endtask

    task automatic expect_head_pop(input string name, input logic [7:0] exp);
        check({name, "_avail"}, 32'(char_available), 32'd1);
        check({name, "_char"}, 32'(char_out), 32'(exp));
        pop_char();
    endtask

    logic [7:0] lcodes [26];
    logic [7:0] b;

    initial begin
        lcodes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                   8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                   8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

        // Each vector leaves modifiers released
        vecs.push_back(mkv(1, 8'h1C, 0, 0, 0, 0, 0, 1'b1, 8'h61));
        vecs.push_back(mkv(1, 8'h32, 0, 0, 0, 0, 0, 1'b1, 8'h62));
        vecs.push_back(mkv(1, 8'h1A, 0, 0, 0, 0, 0, 1'b1, 8'h7A));
        vecs.push_back(mkv(1, 8'h45, 0, 0, 0, 0, 0, 1'b1, 8'h30));
        vecs.push_back(mkv(1, 8'h46, 0, 0, 0, 0, 0, 1'b1, 8'h39));
        vecs.push_back(mkv(4, 8'h12, 8'h16, 8'hF0, 8'h12, 0, 0, 1'b1, 8'h21));
        vecs.push_back(mkv(4, 8'h59, 8'h3E, 8'hF0, 8'h59, 0, 0, 1'b1, 8'h2A));
        vecs.push_back(mkv(4, 8'h59, 8'h1D, 8'hF0, 8'h59, 0, 0, 1'b1, 8'h57));
        vecs.push_back(mkv(4, 8'h12, 8'h45, 8'hF0, 8'h12, 0, 0, 1'b1, 8'h29));
        vecs.push_back(mkv(1, 8'h29, 0, 0, 0, 0, 0, 1'b1, 8'h20));
        vecs.push_back(mkv(1, 8'h5A, 0, 0, 0, 0, 0, 1'b1, 8'h0D));
        vecs.push_back(mkv(1, 8'h66, 0, 0, 0, 0, 0, 1'b1, 8'h08));
        vecs.push_back(mkv(1, 8'h0D, 0, 0, 0, 0, 0, 1'b1, 8'h09));
        vecs.push_back(mkv(1, 8'h76, 0, 0, 0, 0, 0, 1'b1, 8'h1B));
        vecs.push_back(mkv(2, 8'hE0, 8'h5A, 0, 0, 0, 0, 1'b1, 8'h0D));
        vecs.push_back(mkv(2, 8'hE0, 8'h75, 0, 0, 0, 0, 1'b0, 8'h00));
        vecs.push_back(mkv(2, 8'hF0, 8'h1C, 0, 0, 0, 0, 1'b0, 8'h00));
        vecs.push_back(mkv(3, 8'hE0, 8'hF0, 8'h5A, 0, 0, 0, 1'b0, 8'h00));
        vecs.push_back(mkv(4, 8'h14, 8'h21, 8'hF0, 8'h14, 0, 0, 1'b1, 8'h03));
        vecs.push_back(mkv(6, 8'hE0, 8'h14, 8'h2C, 8'hE0, 8'hF0, 8'h14, 1'b1, 8'h14));
        vecs.push_back(mkv(1, 8'h07, 0, 0, 0, 0, 0, 1'b0, 8'h00));
        vecs.push_back(mkv(2, 8'h12, 8'h12, 0, 0, 0, 0, 1'b0, 8'h00));
        vecs.push_back(mkv(3, 8'hF0, 8'h12, 8'h1C, 0, 0, 0, 1'b1, 8'h61));

        reset          = 1'b0;
        scan_valid     = 1'b0;
        scan_code      = 8'h00;
        scan_error     = 1'b0;
        read_character = 1'b0;
        repeat (3) @(negedge system_clk);
        check("rst_char", 32'(char_out), 32'h0);
        check("rst_avail", 32'(char_available), 32'h0);
        check("rst_count", 32'(char_count), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        reset = 1'b1;

        // Latency and basic make/break
        send_byte(8'h1C);
        check("lat_cycle1", 32'(char_available), 32'd0);
        @(negedge system_clk);
        check("lat_cycle2", 32'(char_available), 32'd1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        settle();
        check("t1_count", 32'(char_count), 32'd1);
        expect_head_pop("t1", 8'h61);
        check("t1_count_after", 32'(char_count), 32'd0);
        check("t1_empty_char", 32'(char_out), 32'h0);

        // Table of key sequences
        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                b = vecs[i].codes[8*k +: 8];
                send_byte(b);
            end
            settle();
            check($sformatf("vec%0d_count", i), 32'(char_count), vecs[i].push ? 32'd1 : 32'd0);
            check($sformatf("vec%0d_char", i), 32'(char_out), 32'(vecs[i].exp));
            if (vecs[i].push) pop_char();
            check($sformatf("vec%0d_drained", i), 32'(char_count), 32'd0);
        end

        // Shift then release
        send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
        settle();
        check("t2_count", 32'(char_count), 32'd2);
        expect_head_pop("t2_0", 8'h41);
        expect_head_pop("t2_1", 8'h61);

        // Caps lock XOR shift
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
        send_byte(8'h12); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12);
        send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
        settle();
        check("t3_count", 32'(char_count), 32'd3);
        expect_head_pop("t3_0", 8'h41);
        expect_head_pop("t3_1", 8'h61);
        expect_head_pop("t3_2", 8'h61);

        // Receiver error drops the break prefix but keeps caps
        send_byte(8'h58);
        send_byte(8'hF0);
        @(negedge system_clk); scan_error = 1'b1;
        @(negedge system_clk); scan_error = 1'b0;
        send_byte(8'h1C);
        @(negedge system_clk);
        scan_valid = 1'b1; scan_code = 8'h32; scan_error = 1'b1;
        @(negedge system_clk);
        scan_valid = 1'b0; scan_code = 8'h00; scan_error = 1'b0;
        settle();
        check("err_count", 32'(char_count), 32'd1);
        expect_head_pop("err", 8'h41);
        send_byte(8'h58);
        settle();

        // Fill past full: the 17th character is dropped
        for (int i = 0; i <= DEPTH; i++) send_byte(lcodes[i]);
        settle();
        check("ovf_count", 32'(char_count), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_head", 32'(char_out), 32'h61);

        // Push and pop in the same cycle while full
        @(negedge system_clk); scan_valid = 1'b1; scan_code = lcodes[17];
        @(negedge system_clk); scan_valid = 1'b0; scan_code = 8'h00; read_character = 1'b1;
        @(negedge system_clk); read_character = 1'b0;
        check("full_pp_count", 32'(char_count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            expect_head_pop($sformatf("drain%0d", i), (i < DEPTH - 1) ? 8'(8'h62 + i) : 8'h72);
        check("drain_count", 32'(char_count), 32'd0);
        check("drain_ovf_sticky", 32'(overflow), 32'd1);
        pop_char();
        check("pop_empty_count", 32'(char_count), 32'd0);

        // Reset mid-stream after a break prefix
        send_byte(8'h1C);
        send_byte(8'hF0);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_char", 32'(char_out), 32'h0);
        check("mid_rst_avail", 32'(char_available), 32'h0);
        check("mid_rst_count", 32'(char_count), 32'h0);
        check("mid_rst_ovf", 32'(overflow), 32'h0);
        @(negedge system_clk); reset = 1'b1;
        send_byte(8'h1C);
        settle();
        check("post_rst_count", 32'(char_count), 32'd1);
        expect_head_pop("post_rst", 8'h61);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
